// File: rtl/fxp_udiv_q4p4_iter.sv
// Iterative unsigned Q(W-F).F divider: restoring shift/subtract, one quotient bit per cycle.
// val/rdy handshake on both sides; result and overflow are held in DONE until taken.
module fxp_udiv_q4p4_iter #(
  parameter int W = 8,
  parameter int F = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_val,
  output logic         in_rdy,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  output logic         out_val,
  input  logic         out_rdy,
  output logic [W-1:0] out,
  output logic         overflow
);

  localparam int N  = W + F;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_next;
  logic [N-1:0]   dvd;
  logic [W-1:0]   dsr;
  logic [W:0]     rem;
  logic [N-1:0]   quot;
  logic [CW-1:0]  cnt;

  logic [W+1:0]   trial;
  logic [W+1:0]   diff;
  logic           take;
  logic [N-1:0]   q_next;
  logic           last;

  always_comb begin
    trial  = {rem, dvd[N-1]};
    diff   = trial - {2'b00, dsr};
    take   = trial >= {2'b00, dsr};
    q_next = {quot[N-2:0], take};
    last   = (cnt == CW'(N - 1));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_val)  state_next = CALC;
      CALC:    if (last)    state_next = DONE;
      DONE:    if (out_rdy) state_next = IDLE;
      default:              state_next = IDLE;
    endcase
  end

  assign in_rdy  = (state == IDLE);
  assign out_val = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      out      <= '0;
      overflow <= '0;
    end else begin
      state <= state_next;
      // D == 0 drives every quotient bit to 1, so the upper-bit test already flags it
      if (state == CALC && last) begin
        overflow <= (|q_next[N-1:W]) || (dsr == '0);
        out      <= ((|q_next[N-1:W]) || (dsr == '0)) ? '0 : q_next[W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (in_val) begin
        dvd  <= {in0, {F{1'b0}}};
        dsr  <= in1;
        rem  <= '0;
        quot <= '0;
        cnt  <= '0;
      end
      CALC: begin
        rem  <= take ? diff[W:0] : trial[W:0];
        dvd  <= {dvd[N-2:0], 1'b0};
        quot <= q_next;
        cnt  <= cnt + CW'(1);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fxp_udiv_q4p4_iter.sv
// Directed bench for fxp_udiv_q4p4_iter: hand-computed quotients, latency, stall and reset.
module tb_fxp_udiv_q4p4_iter;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_val;
  logic       in_rdy;
  logic [7:0] in0;
  logic [7:0] in1;
  logic       out_val;
  logic       out_rdy;
  logic [7:0] out;
  logic       overflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  fxp_udiv_q4p4_iter #(.W(8), .F(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in0      (in0),
    .in1      (in1),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out      (out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Drive a request at a negedge, accept on the following posedge, then count
  // cycles (accept cycle = 0) until out_val rises. Operands are scrambled
  // after the accept to confirm they are sampled only once.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    check("rdy_before_req", {31'b0, in_rdy}, 32'd1);
    in0 = a; in1 = b; in_val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_val = 1'b0; in0 = 8'hA5; in1 = 8'h5A;
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_out, input logic exp_ovf);
    int unsigned n;
    start_op(a, b);
    n = 1;
    while (!out_val && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 32'd13);
    check({tag, "_out"}, {24'b0, out}, {24'b0, exp_out});
    check({tag, "_ovf"}, {31'b0, overflow}, {31'b0, exp_ovf});
    check({tag, "_in_rdy_done"}, {31'b0, in_rdy}, 32'd0);
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
    check({tag, "_handoff"}, {30'b0, out_val, in_rdy}, 32'b01);
  endtask

  initial begin
    reset = 1'b1; in_val = 1'b0; in0 = '0; in1 = '0; out_rdy = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_in_rdy", {31'b0, in_rdy}, 32'd1);
    check("rst_out_val", {31'b0, out_val}, 32'd0);
    check("rst_out", {24'b0, out}, 32'h00);
    check("rst_ovf", {31'b0, overflow}, 32'd0);

    run_op("d1p5_0p5", 8'h18, 8'h08, 8'h30, 1'b0);
    run_op("d1_3",     8'h10, 8'h30, 8'h05, 1'b0);
    run_op("d15_0p5",  8'hF0, 8'h08, 8'h00, 1'b1);
    run_op("div0",     8'h10, 8'h00, 8'h00, 1'b1);
    run_op("d7_2",     8'h70, 8'h20, 8'h38, 1'b0);

    // Stall in DONE with a competing request present
    begin
      int unsigned n;
      start_op(8'h30, 8'h10);
      n = 1;
      while (!out_val && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("stall_latency", n, 32'd13);
      in_val = 1'b1; in0 = 8'h01; in1 = 8'h01;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check("stall_out_val", {31'b0, out_val}, 32'd1);
        check("stall_in_rdy", {31'b0, in_rdy}, 32'd0);
        check("stall_out", {24'b0, out}, 32'h30);
        check("stall_ovf", {31'b0, overflow}, 32'd0);
      end
      in_val = 1'b0;
      out_rdy = 1'b1;
      @(negedge clk);
      out_rdy = 1'b0;
      check("stall_release", {30'b0, out_val, in_rdy}, 32'b01);
    end

    // Reset during the 6th CALC cycle discards the operation
    start_op(8'h18, 8'h08);
    repeat (5) @(negedge clk);
    check("mid_calc_busy", {30'b0, out_val, in_rdy}, 32'b00);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_in_rdy", {31'b0, in_rdy}, 32'd1);
    check("midrst_out_val", {31'b0, out_val}, 32'd0);
    check("midrst_out", {24'b0, out}, 32'h00);
    check("midrst_ovf", {31'b0, overflow}, 32'd0);

    run_op("dff_1", 8'hFF, 8'h10, 8'hFF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
